// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and limits for the bit-serial subtractor
package serial_subtractor_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - combinational one-bit full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bor_in,
  output logic diff,
  output logic bor_out
);

  assign diff    = a ^ b ^ bor_in;
  assign bor_out = (~a & b) | (~(a ^ b) & bor_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial A - B with start/busy/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow_out,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] d_vec;
  logic [CW-1:0]    count;
  logic             bor;
  logic             bor_next;
  logic             d;
  logic             a_msb;
  logic             b_msb;
  logic             last_bit;

  full_subtractor u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .bor_in (bor),
    .diff   (d),
    .bor_out(bor_next)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  // New bit enters at the MSB end so the result is aligned after WIDTH shifts
  always_comb begin
    d_vec            = '0;
    d_vec[WIDTH-1]   = d;
    r_next           = (r_sr >> 1) | d_vec;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      count      <= '0;
      bor        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      Diff       <= '0;
      Borrow_out <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            r_sr  <= '0;
            count <= '0;
            bor   <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= r_next;
          bor   <= bor_next;
          count <= count + 1'b1;
          // Results are published only once, so observers never see partial bits
          if (last_bit) begin
            Diff       <= r_next;
            Borrow_out <= bor_next;
            Overflow   <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed checks of serial_subtractor at WIDTH=8 and WIDTH=1
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst8, start8, busy8, done8, bor8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       rst1, start1, busy1, done1, bor1, ovf1;
  logic [0:0] a1, b1, diff1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borrow_out(bor8), .Overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Diff(diff1), .Borrow_out(bor1), .Overflow(ovf1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bor;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy1;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 8) ? done8 : done1;
  endfunction

  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo, input string nm);
    if (w == 8) begin a8 = a; b8 = b; start8 = 1'b1; end
    else begin a1 = a[0]; b1 = b[0]; start1 = 1'b1; end
    tick();
    start8 = 1'b0;
    start1 = 1'b0;
    for (int k = 1; k <= w; k++) begin
      chk($sformatf("%s busy c%0d", nm, k), 32'(busy_of(w)), 32'd1);
      chk($sformatf("%s done c%0d", nm, k), 32'(done_of(w)), 32'd0);
      tick();
    end
    chk($sformatf("%s done", nm), 32'(done_of(w)), 32'd1);
    chk($sformatf("%s busy_at_done", nm), 32'(busy_of(w)), 32'd0);
    if (w == 8) begin
      chk($sformatf("%s diff", nm), 32'(diff8), 32'(ed));
      chk($sformatf("%s borrow", nm), 32'(bor8), 32'(eb));
      chk($sformatf("%s ovf", nm), 32'(ovf8), 32'(eo));
    end else begin
      chk($sformatf("%s diff", nm), 32'(diff1), 32'(ed[0]));
      chk($sformatf("%s borrow", nm), 32'(bor1), 32'(eb));
      chk($sformatf("%s ovf", nm), 32'(ovf1), 32'(eo));
    end
    tick();
  endtask

  initial begin
    int dones;
    int done_cyc;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) tick();
    rst8 = 1'b0;
    rst1 = 1'b0;
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset diff", 32'(diff8), 32'd0);
    chk("reset borrow", 32'(bor8), 32'd0);
    chk("reset ovf", 32'(ovf8), 32'd0);
    chk("reset1 diff", 32'(diff1), 32'd0);

    for (int i = 0; i < 8; i++)
      run_op(8, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor, vecs[i].ovf,
             $sformatf("vec%0d", i));

    // Changing operands and re-pulsing start mid-operation must not disturb the op
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dones = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 2) begin a8 = 8'hAA; b8 = 8'h55; end
      if (cyc == 4) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1; end
      if (cyc == 5) start8 = 1'b0;
      if (done8) begin dones++; done_cyc = cyc; end
      if (cyc >= 9) chk($sformatf("ignore diff c%0d", cyc), 32'(diff8), 32'h0F);
      tick();
    end
    chk("ignore done count", 32'(dones), 32'd1);
    chk("ignore done cycle", 32'(done_cyc), 32'd9);

    // Abort mid-operation
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    chk("abort busy", 32'(busy8), 32'd0);
    chk("abort done", 32'(done8), 32'd0);
    chk("abort diff", 32'(diff8), 32'd0);
    chk("abort borrow", 32'(bor8), 32'd0);
    chk("abort ovf", 32'(ovf8), 32'd0);
    dones = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done8) dones++;
      tick();
    end
    chk("abort no done", 32'(dones), 32'd0);
    run_op(8, 8'h09, 8'h04, 8'h05, 1'b0, 1'b0, "after_abort");

    run_op(1, 8'h00, 8'h01, 8'h01, 1'b1, 1'b1, "w1_0m1");
    run_op(1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, "w1_1m1");
    run_op(1, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, "w1_1m0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing Diff = A - B over WIDTH cycles, LSB first.
- Uses a single full-subtractor cell, the subtract-direction counterpart of the team's full_adder, plus a borrow flop.
- Trades latency for area; intended for datapaths that compute differences (error terms, pointer distances) off the critical path.
- Start/busy/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request a subtraction; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the edge that accepts start.
- B  input  WIDTH  subtrahend; captured on the edge that accepts start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result registers update.
- Diff  output  WIDTH  A - B mod 2^WIDTH.
- Borrow_out  output  1  unsigned borrow: 1 iff A < B unsigned.
- Overflow  output  1  signed overflow of A - B.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, Diff=0, Borrow_out=0, Overflow=0. Internal shift registers, bit counter and borrow flop are also cleared.
- rst has priority over every other input. Asserting it mid-operation aborts the operation, and no done is produced.
- States:
  - IDLE: start=1 at an edge loads A/B into shift regs, sets borrow=0 and count=0, then goes to SHIFT.
  - SHIFT: each cycle the cell computes d=a0^b0^bor and bor_next=(~a0&b0)|(~(a0^b0)&bor). d shifts into the result reg MSB end; the operand regs shift right; count increments. When count==WIDTH-1, go to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Timing: if start is accepted at edge 0, busy=1 for cycles 1..WIDTH, done=1 in cycle WIDTH+1 with busy=0. Total latency is WIDTH+1 cycles from acceptance to done.
- Result update: Diff, Borrow_out and Overflow load only on the SHIFT->DONE transition.
  - Diff = completed result reg.
  - Borrow_out = final borrow.
  - Overflow = (A_msb != B_msb) && (Diff_msb != A_msb), using the captured A/B msbs.
- Result hold: these outputs hold their values until the next result update or reset. They are never X and never show partial results.
- start while busy or in DONE is ignored; no queuing. Back-to-back throughput is one op per WIDTH+2 cycles.
- A/B may change freely after acceptance; only the captured values are used.
- WIDTH=1: a single SHIFT cycle; count compares against 0.
- No combinational path from any input to any output.

Decomposition:
- Shared package: state encoding typedef (IDLE, SHIFT, DONE) and a MAX_WIDTH=32 constant used for parameter checking.
- One natural sub-module: full_subtractor (inputs a, b, bor_in; outputs diff, bor_out).
  - Purely combinational; mirrors the existing adder cell.
  - Instantiated once and fed from the shift-register LSBs and the borrow flop.

Test Plan:
- WIDTH=8, A=0x05, B=0x03, start pulsed at edge 0 -> busy cycles 1..8, done in cycle 9; Diff=0x02, Borrow_out=0, Overflow=0.
- A=0x03, B=0x05 -> Diff=0xFE, Borrow_out=1, Overflow=0. A=0x00, B=0x00 -> Diff=0x00, Borrow_out=0, Overflow=0.
- A=0x80, B=0x01 -> Diff=0x7F, Borrow_out=0, Overflow=1. A=0x7F, B=0xFF -> Diff=0x80, Borrow_out=1, Overflow=1.
- Start at edge 0 with A=0x10, B=0x01; start re-pulsed at edge 4 with A=0xFF, B=0xFF; A/B changed at edge 2 -> exactly one done, in cycle 9, with Diff=0x0F. Outputs hold 0x0F until the next accepted op completes.
- rst asserted at cycle 5 of an op -> next cycle shows IDLE with all outputs 0 and no done. A new start afterwards completes normally, e.g. 0x09-0x04 -> 0x05.
- WIDTH=1 build: A=0, B=1 -> done in cycle 2, Diff=1, Borrow_out=1, Overflow=1. A=1, B=1 -> Diff=0, Borrow_out=0, Overflow=0.
